layer1_maxpool: RTL and testbench

Standalone downstream stage of the atrous-convolution engine. Once the 64x64 layer-0 feature map is fully written to the layer-0 memory, this block computes the 32x32 layer-1 map.
- Reads the layer-0 map over the shared memory bus.
- Applies a 2x2, stride-2 max-pool.
- Rounds each maximum up to an integer.
- Writes results to layer-1 memory in raster order.

It uses the same crd/cwr/csel memory protocol as the convolution stage, so both stages can share the layer-0/layer-1 memory pair.

---
 rtl/layer1_maxpool.sv | 112 +++++++++++
 tb/tb_layer1_maxpool.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_maxpool.sv
// Layer-1 2x2 stride-2 max-pool over the 64x64 layer-0 map, writing a 32x32 map in raster order.
// Optional macro POOL_CEIL_EN compiles in round-up-to-integer with saturation on the pooled value.
module layer1_maxpool (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [12:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [12:0] cdata_wr,
  output logic        csel
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StRd2, StRd3, StWr, StFin} state_e;

  state_e      r_state, w_state_nxt;
  logic [9:0]  r_o, w_o_nxt;
  logic [12:0] r_m, w_m_nxt, w_m_max;
  logic        w_dy, w_dx, w_nxt_rd;

  assign w_m_max = (cdata_rd > r_m) ? cdata_rd : r_m;

  always_comb begin
    w_state_nxt = r_state;
    w_o_nxt     = r_o;
    w_m_nxt     = r_m;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StRd0;
          w_o_nxt     = 10'd0;
        end
      end
      StRd0: begin
        w_state_nxt = StRd1;
        w_m_nxt     = cdata_rd;
      end
      StRd1: begin
        w_state_nxt = StRd2;
        w_m_nxt     = w_m_max;
      end
      StRd2: begin
        w_state_nxt = StRd3;
        w_m_nxt     = w_m_max;
      end
      StRd3: begin
        w_state_nxt = StWr;
        w_m_nxt     = w_m_max;
      end
      StWr: begin
        w_o_nxt     = r_o + 10'd1;
        w_state_nxt = (r_o == 10'd1023) ? StFin : StRd0;
      end
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Window offsets follow the state being entered so the address is registered with it.
  assign w_nxt_rd = w_state_nxt inside {StRd0, StRd1, StRd2, StRd3};
  assign w_dy     = w_state_nxt inside {StRd2, StRd3};
  assign w_dx     = w_state_nxt inside {StRd1, StRd3};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_o      <= 10'd0;
      r_m      <= 13'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 1'b0;
      caddr_rd <= 12'd0;
      caddr_wr <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_o     <= w_o_nxt;
      r_m     <= w_m_nxt;
      busy    <= w_nxt_rd || (w_state_nxt == StWr);
      done    <= (w_state_nxt == StFin);
      crd     <= w_nxt_rd;
      cwr     <= (w_state_nxt == StWr);
      csel    <= (w_state_nxt == StWr);
      if (w_nxt_rd) begin
        caddr_rd <= {w_o_nxt[9:5], w_dy, w_o_nxt[4:0], w_dx};
      end
      if (w_state_nxt == StWr) begin
        caddr_wr <= {2'b00, w_o_nxt};
      end
    end
  end

`ifdef POOL_CEIL_EN
  always_comb begin
    if (r_m[3:0] == 4'd0) begin
      cdata_wr = r_m;
    end else if (r_m[12:4] == 9'h1FF) begin
      cdata_wr = 13'h1FF0;
    end else begin
      cdata_wr = {r_m[12:4] + 9'd1, 4'b0000};
    end
  end
`else
  assign cdata_wr = r_m;
`endif

endmodule

// File: tb/tb_layer1_maxpool.sv
// Scoreboard bench for layer1_maxpool: memory models, expected read/write queues, handshake,
// mid-run reset and full-map checks.
module tb_layer1_maxpool;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, crd, cwr, csel;
  logic [11:0] caddr_rd, caddr_wr;
  logic [12:0] cdata_rd, cdata_wr;

  logic [12:0] l0[4096];
  logic [12:0] l1[1024];
  logic [12:0] gold[1024];

  int          rdq[$];
  int          waq[$];
  logic [12:0] wdq[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  layer1_maxpool dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  assign cdata_rd = (crd && !csel) ? l0[caddr_rd] : 13'h0;

  always @(posedge clk) begin
    if (cwr && csel) l1[caddr_wr[9:0]] <= cdata_wr;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Directed windows: output index, four window values, expected ceil and raw results.
  typedef struct {
    int          o;
    logic [12:0] v[4];
    logic [12:0] e_ceil;
    logic [12:0] e_raw;
  } win_t;
  win_t wins[4];

  function automatic int win_addr(input int o, input int k);
    int r = o / 32;
    int c = o % 32;
    return (2 * r + k / 2) * 64 + 2 * c + (k % 2);
  endfunction

  function automatic logic [12:0] ref_pool(input int o);
    int m = 0;
    int q;
    for (int k = 0; k < 4; k++) if (int'(l0[win_addr(o, k)]) > m) m = int'(l0[win_addr(o, k)]);
`ifdef POOL_CEIL_EN
    q = ((m + 15) / 16) * 16;
    if (q > 'h1FF0) q = 'h1FF0;
`else
    q = m;
`endif
    return q[12:0];
  endfunction

  task automatic push_expected();
    for (int o = 0; o < 1024; o++) begin
      for (int k = 0; k < 4; k++) rdq.push_back(win_addr(o, k));
      waq.push_back(o);
      wdq.push_back(gold[o]);
    end
  endtask

  // Monitor: compares every read and write the DUT presents against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (crd && cwr) chk("crd_cwr_overlap", 1, 0);
      if (crd) begin
        if (rdq.size() == 0) chk("read_unexpected", int'(caddr_rd), -1);
        else chk("read_addr", int'(caddr_rd), rdq.pop_front());
        if (csel) chk("csel_in_read", 1, 0);
      end
      if (cwr) begin
        wr_count++;
        chk("csel_in_write", int'(csel), 1);
        if (waq.size() == 0) chk("write_unexpected", int'(caddr_wr), -1);
        else begin
          chk("write_addr", int'(caddr_wr), waq.pop_front());
          chk("write_data", int'(cdata_wr), int'(wdq.pop_front()));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_crd"}, int'(crd), 0);
    chk({tag, "_cwr"}, int'(cwr), 0);
    chk({tag, "_csel"}, int'(csel), 0);
    chk({tag, "_caddr_rd"}, int'(caddr_rd), 0);
    chk({tag, "_caddr_wr"}, int'(caddr_wr), 0);
    chk({tag, "_cdata_wr"}, int'(cdata_wr), 0);
  endtask

  // Full run with handshake timing checks; optionally pokes start mid-run.
  task automatic run_map(input bit inject);
    int n = 0;
    wr_count = 0;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
      if (inject && n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
    end
    chk("done_seen", int'(done), 1);
    chk("done_cycle", n, 5121);
    chk("busy_at_done", int'(busy), 0);
    chk("write_count", wr_count, 1024);
    chk("queue_drained", rdq.size() + waq.size(), 0);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  task automatic check_l1(input string tag);
    int bad = 0;
    for (int o = 0; o < 1024; o++) if (l1[o] !== gold[o]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    wins[0].o = 5;  wins[0].v = '{13'h0010, 13'h0023, 13'h0021, 13'h0000};
    wins[0].e_ceil = 13'h0030; wins[0].e_raw = 13'h0023;
    wins[1].o = 6;  wins[1].v = '{13'h0050, 13'h0050, 13'h0050, 13'h0050};
    wins[1].e_ceil = 13'h0050; wins[1].e_raw = 13'h0050;
    wins[2].o = 7;  wins[2].v = '{13'h0100, 13'h1FFF, 13'h0002, 13'h0AB1};
    wins[2].e_ceil = 13'h1FF0; wins[2].e_raw = 13'h1FFF;
    wins[3].o = 8;  wins[3].v = '{13'h1FF0, 13'h0100, 13'h1234, 13'h0FFF};
    wins[3].e_ceil = 13'h1FF0; wins[3].e_raw = 13'h1FF0;

    for (int a = 0; a < 4096; a++) l0[a] = 13'((a * 97 + (a >> 5) * 13) % 8192);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) l0[win_addr(wins[i].o, k)] = wins[i].v[k];
    for (int o = 0; o < 1024; o++) gold[o] = ref_pool(o);
    for (int i = 0; i < 4; i++) begin
`ifdef POOL_CEIL_EN
      gold[wins[i].o] = wins[i].e_ceil;
`else
      gold[wins[i].o] = wins[i].e_raw;
`endif
    end
    for (int o = 0; o < 1024; o++) l1[o] = 13'h0;

    start = 1'b0;
    reset = 1'b1;
    #1;
    check_outputs_zero("reset");
    #20;
    @(negedge clk);
    reset = 1'b0;

    run_map(1'b1);
    check_l1("l1_run1");

    // Second run is cut short by reset during the write of output 500.
    push_expected();
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!(cwr && caddr_wr == 12'd500) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("reach_wr500", int'(cwr && caddr_wr == 12'd500), 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    rdq.delete();
    waq.delete();
    wdq.delete();
    @(negedge clk);
    reset = 1'b0;

    for (int o = 0; o < 1024; o++) l1[o] = 13'h0;
    run_map(1'b0);
    check_l1("l1_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
